// File: rtl/min_os_rx_if.sv
// min_os_rx_if: serial input and virtual switch/button outputs of the MinOS receiver
interface min_os_rx_if;
  logic       RX;
  logic [7:0] SWITCHES;
  logic [3:0] BUTTONS;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  modport master (output RX, input SWITCHES, BUTTONS, FRAME_OK, FRAME_ERR);
  modport slave  (input RX, output SWITCHES, BUTTONS, FRAME_OK, FRAME_ERR);
endinterface

// File: rtl/min_os_rx.sv
// min_os_rx: UART 8N1 receiver decoding two-byte commands into virtual switches and buttons
module min_os_rx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] CMD_SW       = 8'h53,
  parameter logic [7:0] CMD_BTN      = 8'h42
) (
  input logic         CLK,
  input logic         RST,
  min_os_rx_if.slave  bus
);
  localparam int TICK_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam int TMR_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TICK_W-1:0] HALF_END = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_END  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0]  TMR_END  = TMR_W'(TMR_MAX - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam logic [0:0] F_CMD = 1'b0, F_DATA = 1'b1;
  logic              rx_s1, rx_s2;
  logic [1:0]        bit_state;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              byte_valid, byte_err;
  logic [0:0]        frame_state;
  logic              cmd_sw;
  logic [TMR_W-1:0]  timer;
  logic              cmd_known, timer_run, timed_out;
  assign cmd_known = (shift == CMD_SW) || (shift == CMD_BTN);
  assign timer_run = (frame_state == F_DATA) && (bit_state == IDLE);
  assign timed_out = timer_run && (timer == TMR_END);
  // two-flop synchronizer, idle-high after reset so no false start bit
  always_ff @(posedge CLK) begin
    if (RST) {rx_s1, rx_s2} <= 2'b11;
    else     {rx_s1, rx_s2} <= {bus.RX, rx_s1};
  end
  // bit FSM: start-bit qualification at mid-bit, then one sample per bit time
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_state  <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (bit_state)
        IDLE: begin
          tick    <= '0;
          bit_cnt <= '0;
          if (!rx_s2) bit_state <= START;
        end
        START: begin
          tick <= (tick == HALF_END) ? '0 : tick + TICK_W'(1);
          if (tick == HALF_END) bit_state <= rx_s2 ? IDLE : DATA;
        end
        DATA: begin
          tick <= (tick == BIT_END) ? '0 : tick + TICK_W'(1);
          if (tick == BIT_END) begin
            shift   <= {rx_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) bit_state <= STOP;
          end
        end
        default: begin
          tick <= (tick == BIT_END) ? '0 : tick + TICK_W'(1);
          if (tick == BIT_END) begin
            byte_valid <= rx_s2;
            byte_err   <= !rx_s2;
            bit_state  <= IDLE;
          end
        end
      endcase
    end
  end
  // frame FSM: command byte then data byte, with an idle-time limit between them
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_state   <= F_CMD;
      cmd_sw        <= 1'b0;
      timer         <= '0;
      bus.SWITCHES  <= '0;
      bus.BUTTONS   <= '0;
      bus.FRAME_OK  <= 1'b0;
      bus.FRAME_ERR <= 1'b0;
    end else begin
      bus.FRAME_OK  <= byte_valid && (frame_state == F_DATA);
      bus.FRAME_ERR <= byte_err || (byte_valid && (frame_state == F_CMD) && !cmd_known) ||
                       (!byte_valid && !byte_err && timed_out);
      if (byte_err) begin
        frame_state <= F_CMD;
      end else if (byte_valid) begin
        if (frame_state == F_CMD) begin
          if (cmd_known) begin
            frame_state <= F_DATA;
            cmd_sw      <= (shift == CMD_SW);
            timer       <= '0;
          end
        end else begin
          frame_state <= F_CMD;
          if (cmd_sw) bus.SWITCHES <= shift;
          else        bus.BUTTONS  <= shift[3:0];
        end
      end else if (timed_out) begin
        frame_state <= F_CMD;
      end else if (timer_run) begin
        timer <= timer + TMR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_min_os_rx.sv
// tb_min_os_rx: scoreboard bench for the MinOS command receiver
module tb_min_os_rx;
  localparam int CPB = 16, TOB = 20;
  typedef struct {bit ok; logic [7:0] sw; logic [3:0] btn;} ev_t;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  ev_t sb[$];
  logic [7:0] m_sw = 0, last_sw = 0;
  logic [3:0] m_btn = 0, last_btn = 0;
  logic prev_pulse = 0;
  min_os_rx_if bus();
  min_os_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_byte(input logic [7:0] b, input bit stop = 1);
    bus.RX = 0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin bus.RX = b[i]; cyc(CPB); end
    bus.RX = stop; cyc(CPB);
    bus.RX = 1;
  endtask
  task automatic push_ok_sw(input logic [7:0] d);
    m_sw = d;
    sb.push_back('{1'b1, m_sw, m_btn});
  endtask
  task automatic push_ok_btn(input logic [7:0] d);
    m_btn = d[3:0];
    sb.push_back('{1'b1, m_sw, m_btn});
  endtask
  task automatic push_err();
    sb.push_back('{1'b0, m_sw, m_btn});
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.FRAME_OK || bus.FRAME_ERR) begin
        ev_t e;
        check("ok_err_excl", {bus.FRAME_OK, bus.FRAME_ERR}, {1'b0, 1'b1} & {2{bus.FRAME_ERR}} | {1'b1, 1'b0} & {2{bus.FRAME_OK && !bus.FRAME_ERR}});
        check("single_cycle", prev_pulse, 0);
        if (sb.size() == 0) check("unexpected_pulse", {bus.FRAME_OK, bus.FRAME_ERR}, 0);
        else begin
          e = sb.pop_front();
          check("kind_ok", bus.FRAME_OK, e.ok);
          check("switches", bus.SWITCHES, e.sw);
          check("buttons", bus.BUTTONS, e.btn);
        end
      end
      if (!bus.FRAME_OK) begin
        check("sw_hold", bus.SWITCHES, last_sw);
        check("btn_hold", bus.BUTTONS, last_btn);
      end
    end
    prev_pulse = !rst && (bus.FRAME_OK || bus.FRAME_ERR);
    last_sw = bus.SWITCHES;
    last_btn = bus.BUTTONS;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.RX = 1;
    cyc(4);
    @(negedge clk);
    check("rst_sw", bus.SWITCHES, 0);
    check("rst_btn", bus.BUTTONS, 0);
    check("rst_ok", bus.FRAME_OK, 0);
    check("rst_err", bus.FRAME_ERR, 0);
    @(posedge clk); #1; rst = 0;
    cyc(2 * CPB);
    push_ok_sw(8'hA5);
    send_byte(8'h53); send_byte(8'hA5); cyc(2 * CPB);
    push_ok_btn(8'hF9);
    send_byte(8'h42); send_byte(8'hF9); cyc(2 * CPB);
    push_err();
    send_byte(8'h53); send_byte(8'h3C, 0); cyc(3 * CPB);
    push_ok_sw(8'h3C);
    send_byte(8'h53); send_byte(8'h3C); cyc(2 * CPB);
    push_err();
    send_byte(8'h53);
    n = 0;
    while (!bus.FRAME_ERR && n < 400) begin @(negedge clk); n++; end
    check("timeout_window", (n >= 300 && n <= 330), 1);
    cyc(21 * CPB - n);
    push_err();
    send_byte(8'h77); cyc(2 * CPB);
    bus.RX = 0; cyc(4); bus.RX = 1; cyc(3 * CPB);
    push_ok_sw(8'h66);
    send_byte(8'h53); send_byte(8'h66); cyc(2 * CPB);
    check("sb_drained_pre_rst", sb.size(), 0);
    bus.RX = 0; cyc(CPB);
    for (int i = 0; i < 4; i++) begin bus.RX = i[0]; cyc(CPB); end
    bus.RX = 0; cyc(CPB / 2);
    rst = 1; cyc(3); bus.RX = 1;
    @(negedge clk);
    check("mid_rst_sw", bus.SWITCHES, 0);
    check("mid_rst_btn", bus.BUTTONS, 0);
    check("mid_rst_ok", bus.FRAME_OK, 0);
    check("mid_rst_err", bus.FRAME_ERR, 0);
    @(posedge clk); #1; rst = 0;
    m_sw = 0; m_btn = 0;
    cyc(2 * CPB);
    push_ok_sw(8'h01);
    send_byte(8'h53); send_byte(8'h01);
    n = 0;
    while (sb.size() != 0 && n < 2000) begin cyc(1); n++; end
    cyc(CPB);
    check("sb_empty", sb.size(), 0);
    check("final_sw", bus.SWITCHES, m_sw);
    check("final_btn", bus.BUTTONS, m_btn);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
